ram_arbiter: RTL and testbench

- Shares the single RAM port among three requesters: the coherence data-bus controller (one data port) and the two per-core instruction caches.
- Sits between the RAM model and the data-bus controller / icaches; the RAM sees only one requester at a time.
- Arbitration policy: data has priority; the two icaches are served round-robin; a starvation counter bounds how long the icaches wait; locked data block sequences are never split.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/rr_pick2.sv | 19 +
 rtl/ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory subsystem: machine word and RAM arbiter states.
package cpu_types_pkg;

   // One machine word / word address.
   typedef logic [31:0] word_t;

   // RAM arbiter ownership states: nobody, the data bus, or one icache.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

   // Default number of completed data words an icache may wait behind.
   localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: chooses between two requesters, favouring rr on a tie.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       rr,
   output logic       grant,
   output logic       valid
);

   // Tie goes to the favoured index; otherwise the lone requester wins.
   always_comb begin
      valid = |req;
      if (req == 2'b11) begin
         grant = rr;
      end else begin
         grant = req[1];
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between the data-bus controller and two icaches.
// Data has priority, icaches alternate, and a starvation counter forces an
// icache grant after STARVE_LIMIT data words unless the data bus holds dlock.
//
// Handshake: a requester raises its REN/WEN and holds address/data stable;
// its wait output stays 1 and drops to 0 for exactly the one cycle in which
// the RAM completes the word (ramwait=0). Dropping the request before that
// cycle abandons the access and returns the arbiter to IDLE.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS         = 2,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                               CLK,
   input  logic                               RST,
   // icache side
   input  logic  [CPUS-1:0]                   iREN,
   input  word_t [CPUS-1:0]                   iaddr,
   output logic  [CPUS-1:0]                   iwait,
   output word_t [CPUS-1:0]                   iload,
   // data-bus side
   input  logic                               dREN,
   input  logic                               dWEN,
   input  logic                               dlock,
   input  word_t                              daddr,
   input  word_t                              dstore,
   output logic                               dwait,
   output word_t                              dload,
   // RAM side
   output logic                               ramREN,
   output logic                               ramWEN,
   output word_t                              ramaddr,
   output word_t                              ramstore,
   input  word_t                              ramload,
   input  logic                               ramwait,
   // observability
   output arb_state_t                         dbg_state,
   output logic [$clog2(STARVE_LIMIT+1)-1:0]  dbg_starve
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t    state, state_nxt;
   logic          ipick, ipick_nxt;
   logic          rr, rr_nxt;
   logic [SW-1:0] starve, starve_nxt;

   logic d_req, i_req;
   logic d_done, i_done;
   logic pick_idx, pick_valid;
   logic arb_go;

   assign dbg_state  = state;
   assign dbg_starve = starve;

   // Word completion detection and next values of the fairness counters.
   always_comb begin
      d_req      = dREN | dWEN;
      i_req      = iREN[ipick];
      d_done     = (state == DGRANT) && d_req && !ramwait;
      i_done     = (state == IGRANT) && i_req && !ramwait;
      rr_nxt     = rr;
      starve_nxt = starve;
      if (d_done) begin
         if (|iREN) begin
            starve_nxt = (starve == STARVE_MAX) ? starve : starve + SW'(1);
         end else begin
            starve_nxt = '0;
         end
      end else if (i_done) begin
         rr_nxt     = !ipick;
         starve_nxt = '0;
      end
   end

   // Icache choice uses the post-completion favour bit so alternation holds back-to-back.
   rr_pick2 u_pick (
      .req   (iREN[1:0]),
      .rr    (rr_nxt),
      .grant (pick_idx),
      .valid (pick_valid)
   );

   // Port muxing, wait/load routing and next-state arbitration.
   always_comb begin
      iwait     = '1;
      iload     = '0;
      dwait     = 1'b1;
      dload     = '0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      state_nxt = state;
      ipick_nxt = ipick;
      arb_go    = 1'b0;

      if (!RST) begin
         unique case (state)
            IDLE: begin
               arb_go = 1'b1;
            end
            DGRANT: begin
               if (d_req) begin
                  ramaddr  = daddr;
                  ramstore = dstore;
                  ramWEN   = dWEN;
                  ramREN   = dREN & ~dWEN;   // a simultaneous write wins
                  dwait    = ramwait;
                  if (dREN) begin
                     dload = ramload;
                  end
                  arb_go = !ramwait;
               end else begin
                  // Owner withdrew: abandon the access, counters untouched.
                  state_nxt = IDLE;
               end
            end
            IGRANT: begin
               if (i_req) begin
                  ramREN       = 1'b1;
                  ramaddr      = iaddr[ipick];
                  iwait[ipick] = ramwait;
                  iload[ipick] = ramload;
                  arb_go       = !ramwait;
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase

         if (arb_go) begin
            if ((state == DGRANT) && dlock) begin
               state_nxt = DGRANT;
            end else if (pick_valid && (starve_nxt == STARVE_MAX)) begin
               state_nxt = IGRANT;
               ipick_nxt = pick_idx;
            end else if (d_req) begin
               state_nxt = DGRANT;
            end else if (pick_valid) begin
               state_nxt = IGRANT;
               ipick_nxt = pick_idx;
            end else begin
               state_nxt = IDLE;
            end
         end
      end
   end

   // State and fairness registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         ipick  <= 1'b0;
         rr     <= 1'b0;
         starve <= '0;
      end else begin
         state  <= state_nxt;
         ipick  <= ipick_nxt;
         rr     <= rr_nxt;
         starve <= starve_nxt;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations plus a
// long randomized run checked every cycle against an ownership-level model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 4;
  localparam int OWN_NONE = 0;
  localparam int OWN_DATA = 1;
  localparam int OWN_I    = 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  // ---------------- DUT signals ----------------
  logic  [1:0] iREN;
  word_t [1:0] iaddr;
  logic  [1:0] iwait;
  word_t [1:0] iload;
  logic        dREN, dWEN, dlock;
  word_t       daddr, dstore, dload;
  logic        dwait;
  logic        ramREN, ramWEN, ramwait;
  word_t       ramaddr, ramstore, ramload;
  arb_state_t  dbg_state;
  logic [2:0]  dbg_starve;

  ram_arbiter #(.CPUS(2), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .dlock(dlock), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait),
    .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = OWN_NONE, m_core = 0, m_rr = 0, m_starve = 0;
  int nxt_owner = OWN_NONE, nxt_core = 0, nxt_rr = 0, nxt_starve = 0;
  logic [1:0]  e_iwait;
  logic [31:0] e_iload0, e_iload1, e_dload, e_ramaddr, e_ramstore;
  logic        e_dwait, e_ramREN, e_ramWEN;

  function automatic arb_state_t owner_state(input int own);
    if (own == OWN_DATA) return DGRANT;
    if (own == OWN_I) return IGRANT;
    return IDLE;
  endfunction

  // Expected outputs for this cycle and who owns the port next cycle.
  task automatic model_eval();
    bit arbitrate;
    bit hold;
    int pick;
    e_iwait = 2'b11; e_iload0 = '0; e_iload1 = '0; e_dwait = 1'b1; e_dload = '0;
    e_ramREN = 1'b0; e_ramWEN = 1'b0; e_ramaddr = '0; e_ramstore = '0;
    nxt_owner = m_owner; nxt_core = m_core; nxt_rr = m_rr; nxt_starve = m_starve;
    arbitrate = 1'b0;
    hold = 1'b0;
    if (RST) begin
      nxt_owner = OWN_NONE; nxt_rr = 0; nxt_starve = 0; nxt_core = 0;
    end else begin
      if (m_owner == OWN_NONE) begin
        arbitrate = 1'b1;
      end else if (m_owner == OWN_DATA) begin
        if (dREN || dWEN) begin
          e_ramaddr = daddr; e_ramstore = dstore;
          e_ramWEN = dWEN; e_ramREN = dREN && !dWEN;
          e_dwait = ramwait;
          if (dREN) e_dload = ramload;
          if (!ramwait) begin
            arbitrate = 1'b1;
            hold = dlock;
            if (iREN != 2'b00) nxt_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            else nxt_starve = 0;
          end
        end else begin
          nxt_owner = OWN_NONE;
        end
      end else begin
        if (iREN[m_core[0]]) begin
          e_ramREN = 1'b1;
          e_ramaddr = iaddr[m_core[0]];
          e_iwait[m_core[0]] = ramwait;
          if (m_core == 0) e_iload0 = ramload; else e_iload1 = ramload;
          if (!ramwait) begin
            arbitrate = 1'b1;
            nxt_rr = 1 - m_core;
            nxt_starve = 0;
          end
        end else begin
          nxt_owner = OWN_NONE;
        end
      end
      if (arbitrate) begin
        pick = (iREN == 2'b11) ? nxt_rr : (iREN[1] ? 1 : 0);
        if (hold) nxt_owner = OWN_DATA;
        else if (iREN != 2'b00 && nxt_starve == LIMIT) begin nxt_owner = OWN_I; nxt_core = pick; end
        else if (dREN || dWEN) nxt_owner = OWN_DATA;
        else if (iREN != 2'b00) begin nxt_owner = OWN_I; nxt_core = pick; end
        else nxt_owner = OWN_NONE;
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge CLK) begin
    model_eval();
    chk("iwait",    32'(iwait),      32'(e_iwait));
    chk("iload0",   iload[0],        e_iload0);
    chk("iload1",   iload[1],        e_iload1);
    chk("dwait",    32'(dwait),      32'(e_dwait));
    chk("dload",    dload,           e_dload);
    chk("ramREN",   32'(ramREN),     32'(e_ramREN));
    chk("ramWEN",   32'(ramWEN),     32'(e_ramWEN));
    chk("ramaddr",  ramaddr,         e_ramaddr);
    chk("ramstore", ramstore,        e_ramstore);
    chk("state",    32'(dbg_state),  32'(owner_state(m_owner)));
    chk("starve",   32'(dbg_starve), 32'(m_starve));
  end

  // Model state advances on the same edge as the DUT.
  always @(posedge CLK) begin
    m_owner = nxt_owner; m_core = nxt_core; m_rr = nxt_rr; m_starve = nxt_starve;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; iaddr[0] = '0; iaddr[1] = '0;
    dREN = 1'b0; dWEN = 1'b0; dlock = 1'b0; daddr = '0; dstore = '0;
    ramload = '0; ramwait = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();

    // Reset in the middle of a data write.
    RST = 1'b0; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h55; ramwait = 1'b1;
    @(negedge CLK); chk("rmt_idle_wen", 32'(ramWEN), 32'd0);
    tick();
    @(negedge CLK); chk("rmt_grant_wen", 32'(ramWEN), 32'd1);
    chk("rmt_grant_addr", ramaddr, 32'h40);
    tick(); RST = 1'b1;
    @(negedge CLK); chk("rmt_rst_wen", 32'(ramWEN), 32'd0);
    chk("rmt_rst_dwait", 32'(dwait), 32'd1);
    tick(); RST = 1'b0;
    @(negedge CLK); chk("rmt_state", 32'(dbg_state), 32'(IDLE));
    chk("rmt_iwait", 32'(iwait), 32'h3);

    // Data priority over a pending icache, latency 2.
    do_reset();
    dREN = 1'b1; daddr = 32'h10; iREN = 2'b01; iaddr[0] = 32'h100; iaddr[1] = 32'h200;
    ramwait = 1'b1; ramload = 32'hDEADBEEF;
    @(negedge CLK); chk("dp_idle_ren", 32'(ramREN), 32'd0);
    tick();
    @(negedge CLK); chk("dp_ren", 32'(ramREN), 32'd1);
    chk("dp_addr", ramaddr, 32'h10);
    chk("dp_dwait_busy", 32'(dwait), 32'd1);
    tick(); ramwait = 1'b0;
    @(negedge CLK); chk("dp_dwait_done", 32'(dwait), 32'd0);
    chk("dp_dload", dload, 32'hDEADBEEF);
    chk("dp_iwait", 32'(iwait), 32'h3);
    tick(); dREN = 1'b0;
    @(negedge CLK); chk("dp_drop_ren", 32'(ramREN), 32'd0);
    tick();
    @(negedge CLK); chk("dp_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    @(negedge CLK); chk("dp_igrant", 32'(dbg_state), 32'(IGRANT));
    chk("dp_iaddr", ramaddr, 32'h100);
    chk("dp_iwait0", 32'(iwait), 32'h2);
    chk("dp_iload0", iload[0], 32'hDEADBEEF);

    // Round robin between both icaches.
    do_reset();
    iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200; ramload = 32'h1234;
    @(negedge CLK); chk("rr_idle", 32'(dbg_state), 32'(IDLE));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge CLK);
      chk("rr_addr", ramaddr, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_iwait", 32'(iwait), (k % 2 == 0) ? 32'h2 : 32'h1);
    end

    // Starvation bound with a continuous data stream.
    do_reset();
    dREN = 1'b1; daddr = 32'h20; iREN = 2'b10; iaddr[1] = 32'h200;
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge CLK);
      chk("st_dgrant", 32'(dbg_state), 32'(DGRANT));
      chk("st_count", 32'(dbg_starve), 32'(k - 1));
    end
    tick();
    @(negedge CLK); chk("st_igrant", 32'(dbg_state), 32'(IGRANT));
    chk("st_iaddr", ramaddr, 32'h200);
    chk("st_iwait", 32'(iwait), 32'h1);
    chk("st_full", 32'(dbg_starve), 32'd4);
    tick();
    @(negedge CLK); chk("st_resume", 32'(dbg_state), 32'(DGRANT));
    chk("st_zero", 32'(dbg_starve), 32'd0);

    // Locked block is never split.
    do_reset();
    dWEN = 1'b1; dlock = 1'b1; daddr = 32'h30; dstore = 32'h77; iREN = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      @(negedge CLK); chk("lk_dgrant", 32'(dbg_state), 32'(DGRANT));
    end
    chk("lk_sat", 32'(dbg_starve), 32'd4);
    tick(); dlock = 1'b0;
    @(negedge CLK); chk("lk_last", 32'(dbg_state), 32'(DGRANT));
    tick();
    @(negedge CLK); chk("lk_igrant", 32'(dbg_state), 32'(IGRANT));
    chk("lk_iwait", 32'(iwait), 32'h2);

    // Abort, then simultaneous read/write.
    do_reset();
    dREN = 1'b1; daddr = 32'h50; ramwait = 1'b1;
    tick();
    @(negedge CLK); chk("ab_ren", 32'(ramREN), 32'd1);
    tick(); dREN = 1'b0;
    @(negedge CLK); chk("ab_drop_ren", 32'(ramREN), 32'd0);
    chk("ab_dwait", 32'(dwait), 32'd1);
    tick();
    @(negedge CLK); chk("ab_idle", 32'(dbg_state), 32'(IDLE));
    do_reset();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h60; dstore = 32'h99; ramwait = 1'b1;
    tick();
    @(negedge CLK); chk("rw_wen", 32'(ramWEN), 32'd1);
    chk("rw_ren", 32'(ramREN), 32'd0);

    // Randomized traffic, checked by the compare process.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      RST      = ($urandom_range(0, 199) == 0);
      dREN     = ($urandom_range(0, 9) < 6);
      dWEN     = ($urandom_range(0, 9) < 3);
      dlock    = ($urandom_range(0, 3) == 0);
      iREN     = 2'($urandom_range(0, 3));
      iaddr[0] = $urandom;
      iaddr[1] = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramwait  = ($urandom_range(0, 2) == 0);
    end
    tick();
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
